// File: rtl/sparse.sv
// Sparse 16-element unsigned 8-bit dot product: one MAC per pair where both
// operands are non-zero, lowest index first, result published at end of pass.
module sparse (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] Vector_A,
  input  logic [127:0] Vector_B,
  output logic [24:0]  out_Final
);
  localparam int NUM_LANES = 16;
  localparam int VEC_W     = 8;
  localparam int ACC_W     = 21;

  typedef enum logic {LOAD, RUN} state_t;

  state_t                             state;
  logic [NUM_LANES-1:0][VEC_W-1:0]    a_q, b_q;
  logic [NUM_LANES-1:0]               mask, nz;
  logic [ACC_W-1:0]                   acc;
  logic [3:0]                         sel;
  logic                               hit;
  logic [2*VEC_W-1:0]                 prod;

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      assign nz[g] = (|Vector_A[VEC_W*g +: VEC_W]) && (|Vector_B[VEC_W*g +: VEC_W]);
    end
  endgenerate

  // Priority pick: lowest set mask bit wins.
  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!hit && mask[i]) begin
        sel = 4'(i);
        hit = 1'b1;
      end
    end
  end

  assign prod = a_q[sel] * b_q[sel];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= LOAD;
      a_q       <= '0;
      b_q       <= '0;
      mask      <= '0;
      acc       <= '0;
      out_Final <= '0;
    end else begin
      case (state)
        LOAD: begin
          a_q   <= Vector_A;
          b_q   <= Vector_B;
          mask  <= nz;
          acc   <= '0;
          state <= RUN;
        end
        RUN: begin
          if (hit) begin
            acc       <= acc + ACC_W'(prod);
            mask[sel] <= 1'b0;
          end else begin
            out_Final <= {4'b0, acc};
            state     <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_sparse.sv
// Directed bench for sparse: pass timing, operand capture, reset abort.
module tb_sparse;
  logic         clk;
  logic         rst;
  logic [127:0] Vector_A, Vector_B;
  logic [24:0]  out_Final;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [24:0] FULL = 25'h00FE010;

  sparse dut (
    .clk      (clk),
    .rst      (rst),
    .Vector_A (Vector_A),
    .Vector_B (Vector_B),
    .out_Final(out_Final)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [24:0] got, input logic [24:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%07h expected 0x%07h", tag, got, exp);
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b0;
    Vector_A = {16{8'hFF}};
    Vector_B = {16{8'hFF}};
    #12;
    chk("reset_out", out_Final, 25'd0);

    // Full vector: 16 MACs, result on edge 18, repeating every 18.
    step(0); rst = 1'b1;
    step(1);  chk("full_e1", out_Final, 25'd0);
    step(16); chk("full_e17", out_Final, 25'd0);
    step(1);  chk("full_e18", out_Final, FULL);
    step(1);  chk("full_hold_e19", out_Final, FULL);
    step(17); chk("full_e36", out_Final, FULL);

    // Async reset clears output without a clock edge.
    rst = 1'b0; #2;
    chk("async_rst", out_Final, 25'd0);

    // Input change after LOAD is ignored until next pass.
    step(1); rst = 1'b1;
    step(5); Vector_B = '0;
    step(12); chk("capt_e17", out_Final, 25'd0);
    step(1);  chk("capt_e18", out_Final, FULL);
    step(1);  chk("capt_e19", out_Final, FULL);
    step(1);  chk("capt_e20", out_Final, 25'd0);

    // Mid-pass reset: no partial sum reaches the output.
    Vector_B = {16{8'hFF}};
    rst = 1'b0; step(1); rst = 1'b1;
    step(18); chk("abort_pre", out_Final, FULL);
    step(10); rst = 1'b0; #1;
    chk("abort_rst", out_Final, 25'd0);
    step(2);  chk("abort_held", out_Final, 25'd0);
    rst = 1'b1;
    step(17); chk("abort_e17", out_Final, 25'd0);
    step(1);  chk("abort_e18", out_Final, FULL);

    // All-zero mask: result 0 on edge 2.
    Vector_A = {16{8'hFF}};
    Vector_B = '0;
    step(1); chk("k0_e1", out_Final, FULL);
    step(1); chk("k0_e2", out_Final, 25'd0);

    // Single pair at lane 7: 3*7 on edge 3.
    Vector_A = '0; Vector_B = '0;
    Vector_A[63:56] = 8'h03;
    Vector_B[63:56] = 8'h07;
    step(2); chk("k1_e2", out_Final, 25'd0);
    step(1); chk("k1_e3", out_Final, 25'd21);

    // Lanes 0,15 non-zero, lane 5 half-zero: 2*3 + 16*16 on edge 4.
    Vector_A = '0; Vector_B = '0;
    Vector_A[7:0]     = 8'h02; Vector_B[7:0]     = 8'h03;
    Vector_A[127:120] = 8'h10; Vector_B[127:120] = 8'h10;
    Vector_A[47:40]   = 8'hFF; Vector_B[47:40]   = 8'h00;
    step(3); chk("k2_e3", out_Final, 25'd21);
    step(1); chk("k2_e4", out_Final, 25'd262);

    // Next pass with B[0]=5: 2*5 + 256, still 4-cycle period.
    Vector_B[7:0] = 8'h05;
    step(3); chk("k2b_e3", out_Final, 25'd262);
    step(1); chk("k2b_e4", out_Final, 25'd266);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
